// File: rtl/generic_fifo_sc_prog.sv
// generic_fifo_sc_prog: single-clock parametrised FIFO with standard or
// first-word-fall-through read, programmable almost-full/almost-empty
// thresholds, occupancy count and sticky overflow/underflow flags.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clr               synchronous clear (wins over we/re)
//   din, we           write data / write request
//   re                read request (pop)
//   dout              read data (registered, or head word when FWFT=1)
//   full, empty       level == DEPTH / level == 0
//   almost_full       level >= af_thr
//   almost_empty      level <= ae_thr
//   af_thr, ae_thr    run-time thresholds
//   level             occupancy 0..DEPTH
//   overflow          sticky: write refused because full
//   underflow         sticky: read refused because empty
module generic_fifo_sc_prog #(
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 3,
  parameter int unsigned FWFT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] din,
  input  logic          we,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  input  logic [AW:0]   af_thr,
  input  logic [AW:0]   ae_thr,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned LW    = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          wr_ok;
  logic          rd_ok;

  // A read in the same cycle frees a slot, so a full FIFO still takes a write.
  assign rd_ok = re & ~empty;
  assign wr_ok = we & (~full | rd_ok);

  // Flags decode from the level register only, never from live requests.
  assign full         = (level == LW'(DEPTH));
  assign empty        = (level == '0);
  assign almost_full  = (level >= af_thr);
  assign almost_empty = (level <= ae_thr);

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wp        <= '0;
      rp        <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + AW'(1);
      if (rd_ok) rp <= rp + AW'(1);
      level <= level + LW'(wr_ok) - LW'(rd_ok);
      if (we & ~wr_ok) overflow  <= 1'b1;
      if (re & empty)  underflow <= 1'b1;
    end
  end

  // Storage array; contents survive clr since pointers make them unreachable.
  always_ff @(posedge clk) begin
    if (!rst && !clr && wr_ok) mem[wp] <= din;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented continuously; re acknowledges it.
      assign dout = mem[rp];
    end else begin : g_std
      // Registered read: one cycle latency, holds between pops.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        dout <= '0;
        else if (clr)   dout <= '0;
        else if (rd_ok) dout <= mem[rp];
      end
    end
  endgenerate

endmodule
